// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request/response bundle between issue logic and the divider
interface div_unit_if;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic        Done;
  logic [31:0] Result;

  modport master (output Start, Op, A, B, input Busy, Done, Result);
  modport slave  (input Start, Op, A, B, output Busy, Done, Result);
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative RV32M divider (DIV/DIVU/REM/REMU), one quotient bit per cycle
module div_unit (
  input  logic      Clk,
  input  logic      Reset_n,
  div_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t      state_q;
  logic [1:0]  op_q;
  logic        a_neg_q;
  logic        q_neg_q;
  logic        special_q;
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [4:0]  count_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] result_q;

  // Operand capture: magnitudes for signed ops, raw values for unsigned ones
  logic        signed_op;
  logic        a_neg_in;
  logic        b_neg_in;
  logic [31:0] a_mag_in;
  logic [31:0] b_mag_in;
  logic        special_in;

  // Start-side decode of the incoming request
  always_comb begin
    signed_op  = ~bus.Op[0];
    a_neg_in   = signed_op & bus.A[31];
    b_neg_in   = signed_op & bus.B[31];
    a_mag_in   = a_neg_in ? (32'd0 - bus.A) : bus.A;
    b_mag_in   = b_neg_in ? (32'd0 - bus.B) : bus.B;
    special_in = (bus.B == 32'd0) ||
                 (signed_op && (bus.A == 32'h8000_0000) && (bus.B == 32'hFFFF_FFFF));
  end

  // One restoring step: shift {rem, quo} left, subtract the divisor when it fits
  logic [32:0] rem_sh_d;
  logic        fits_d;
  logic [31:0] rem_d;
  logic [31:0] quo_d;

  // Restoring-division step; the remainder stays below the divisor so 32 bits hold it
  always_comb begin
    rem_sh_d = {rem_q, quo_q[31]};
    fits_d   = rem_sh_d >= {1'b0, dvs_q};
    rem_d    = fits_d ? (rem_sh_d[31:0] - dvs_q) : rem_sh_d[31:0];
    quo_d    = {quo_q[30:0], fits_d};
  end

  // Final result selection, including divide-by-zero and signed-overflow cases
  logic [31:0] fin_d;

  // Sign fix-up of quotient/remainder; in the special path quo_q still holds |A|
  always_comb begin
    fin_d = 32'd0;
    if (special_q) begin
      if (dvs_q == 32'd0) begin
        fin_d = op_q[1] ? (a_neg_q ? (32'd0 - quo_q) : quo_q) : 32'hFFFF_FFFF;
      end else begin
        fin_d = op_q[1] ? 32'd0 : 32'h8000_0000;
      end
    end else if (op_q[1]) begin
      fin_d = a_neg_q ? (32'd0 - rem_q) : rem_q;
    end else begin
      fin_d = q_neg_q ? (32'd0 - quo_q) : quo_q;
    end
  end

  // Control FSM and datapath registers; Busy/Done/Result are registered outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= IDLE;
      op_q      <= 2'b00;
      a_neg_q   <= 1'b0;
      q_neg_q   <= 1'b0;
      special_q <= 1'b0;
      rem_q     <= 32'd0;
      quo_q     <= 32'd0;
      dvs_q     <= 32'd0;
      count_q   <= 5'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.Start) begin
            op_q      <= bus.Op;
            a_neg_q   <= a_neg_in;
            q_neg_q   <= a_neg_in ^ b_neg_in;
            special_q <= special_in;
            rem_q     <= 32'd0;
            quo_q     <= a_mag_in;
            dvs_q     <= b_mag_in;
            count_q   <= 5'd0;
            busy_q    <= 1'b1;
            state_q   <= special_in ? FIN : CALC;
          end
        end
        CALC: begin
          rem_q   <= rem_d;
          quo_q   <= quo_d;
          count_q <= count_q + 5'd1;
          if (count_q == 5'd31) begin
            state_q <= FIN;
          end
        end
        FIN: begin
          result_q <= fin_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Busy   = busy_q;
  assign bus.Done   = done_q;
  assign bus.Result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit
module tb_div_unit;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  logic Clk;
  logic Reset_n;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  div_unit_if bus ();

  div_unit dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: every Done pops one expectation and checks value and arrival cycle
  always @(negedge Clk) begin
    if (bus.Done === 1'b1) begin
      exp_t e;
      total++;
      if (bus.Busy !== 1'b0) begin
        bad++;
        $display("FAIL busy_with_done busy=%b required=0 cyc=%0d", bus.Busy, cyc);
      end
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done result=%h required=no_done cyc=%0d", bus.Result, cyc);
      end else begin
        e = sb.pop_front();
        if (bus.Result !== e.res) begin
          bad++;
          $display("FAIL result got=%h required=%h cyc=%0d", bus.Result, e.res, cyc);
        end
        total++;
        if (cyc != e.cyc) begin
          bad++;
          $display("FAIL done_cycle got=%0d required=%0d", cyc, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h required=%h", name, act, req);
    end
  endtask

  // Drive one Start pulse; expected Done cycle = Start edge + latency
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int lat, input bit push);
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Op    = op;
    bus.A     = a;
    bus.B     = b;
    if (push) sb.push_back('{res: res, cyc: cyc + 1 + lat});
    @(negedge Clk);
    bus.Start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 120 && sb.size() != 0; i++) begin
      @(negedge Clk);
      #1;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout pending=%0d required=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input int lat);
    issue(op, a, b, res, lat, 1'b1);
    drain();
  endtask

  initial begin
    int t0;
    Reset_n   = 1'b0;
    bus.Start = 1'b0;
    bus.Op    = 2'b00;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    repeat (3) @(negedge Clk);
    chk("reset_busy", {31'd0, bus.Busy}, 32'd0);
    chk("reset_done", {31'd0, bus.Done}, 32'd0);
    chk("reset_result", bus.Result, 32'd0);
    Reset_n = 1'b1;

    // Basic unsigned and signed arithmetic
    run(OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run(OP_REMU, 32'd100, 32'd7, 32'd2, 33);
    run(OP_DIV,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33);
    run(OP_REM,  32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 33);
    run(OP_DIV,  32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
    run(OP_DIV,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 33);
    run(OP_REM,  32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33);
    run(OP_REM,  32'd21, 32'hFFFF_FFF9, 32'd0, 33);

    // Divide by zero (fast path)
    run(OP_DIV,  32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
    run(OP_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1);
    run(OP_REMU, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);
    run(OP_REM,  32'hFFFF_FF9C, 32'd0, 32'hFFFF_FF9C, 1);

    // Signed overflow (fast path) versus the unsigned equivalent (full path)
    run(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run(OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
    run(OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);

    // Start while busy is ignored
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 1'b1);
    repeat (5) @(negedge Clk);
    chk("busy_in_calc", {31'd0, bus.Busy}, 32'd1);
    bus.Start = 1'b1;
    bus.Op    = OP_DIVU;
    bus.A     = 32'd9;
    bus.B     = 32'd3;
    @(negedge Clk);
    bus.Start = 1'b0;
    drain();
    repeat (40) @(negedge Clk);
    chk("idle_after_ignored", {31'd0, bus.Busy}, 32'd0);

    // Start held high: two operations, 34 cycles apart
    @(negedge Clk);
    bus.Start = 1'b1;
    bus.Op    = OP_DIVU;
    bus.A     = 32'd100;
    bus.B     = 32'd7;
    t0 = cyc;
    sb.push_back('{res: 32'd14, cyc: t0 + 34});
    sb.push_back('{res: 32'd14, cyc: t0 + 68});
    for (int i = 0; i < 60 && cyc < t0 + 35; i++) @(negedge Clk);
    bus.Start = 1'b0;
    drain();
    repeat (40) @(negedge Clk);

    // Reset in the middle of CALC aborts without a Done
    issue(OP_DIVU, 32'd100, 32'd7, 32'd0, 0, 1'b0);
    repeat (10) @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, bus.Busy}, 32'd0);
    chk("abort_done", {31'd0, bus.Done}, 32'd0);
    chk("abort_result", bus.Result, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (40) @(negedge Clk);
    chk("abort_result_held", bus.Result, 32'd0);
    run(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);

    repeat (5) @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
